// File: rtl/instruction_fetch.sv
// Fetch stage: issues in-order word fetches, buffers returned words in a small FIFO and
// discards stale responses after a redirect.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [63:0] i_redirect_pc,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [63:0] o_imem_req_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  output logic        o_ifid_valid,
  output logic [63:0] o_ifid_pc,
  output logic [31:0] o_ifid_instruction
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DepthW = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e        state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] in_flight_q, in_flight_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  logic [63:0]   fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]   fifo_instr_q [FIFO_DEPTH];

  logic          pop;
  logic          push;
  logic          req_fire;
  logic          rsp_accept;
  logic          rsp_drop;
  logic          credit_ok;
  logic [CW:0]   occupancy;
  logic [CW-1:0] remaining;
  logic [63:0]   redirect_pc;

  assign redirect_pc = i_redirect_pc & ~64'h3;

  assign pop       = (count_q != '0) & ~i_stall;
  // Credit counts words already promised to the FIFO, net of this cycle's pop.
  assign occupancy = (CW + 1)'(in_flight_q) + (CW + 1)'(count_q) - (CW + 1)'(pop);
  assign credit_ok = occupancy < DepthW;

  assign o_imem_req_valid = (state_q == StRun) & ~i_redirect & ~i_rst & credit_ok;
  assign o_imem_req_addr  = fetch_pc_q;
  assign req_fire         = o_imem_req_valid & i_imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_accept = i_imem_rsp_valid & (in_flight_q != '0);
  assign rsp_drop   = rsp_accept & (drop_cnt_q != '0);
  assign push       = rsp_accept & ~rsp_drop & ~i_redirect;
  assign remaining  = in_flight_q - CW'(rsp_accept);

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    rsp_pc_d    = rsp_pc_q;
    in_flight_d = in_flight_q;
    drop_cnt_d  = drop_cnt_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;

    if (i_redirect) begin
      fetch_pc_d  = redirect_pc;
      rsp_pc_d    = redirect_pc;
      in_flight_d = remaining;
      drop_cnt_d  = remaining;
      count_d     = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      state_d     = (remaining != '0) ? StFlush : StRun;
    end else begin
      in_flight_d = in_flight_q + CW'(req_fire) - CW'(rsp_accept);
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 64'd4;
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
        if (drop_cnt_q == CW'(1)) begin
          state_d = StRun;
        end
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + 64'd4;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StRun;
      fetch_pc_q  <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      in_flight_q <= '0;
      drop_cnt_q  <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      rsp_pc_q    <= rsp_pc_d;
      in_flight_q <= in_flight_d;
      drop_cnt_q  <= drop_cnt_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  // Storage needs no reset; the head is gated by o_ifid_valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= rsp_pc_q;
      fifo_instr_q[wr_ptr_q] <= i_imem_rsp_data;
    end
  end

  assign o_ifid_valid       = (count_q != '0);
  assign o_ifid_pc          = o_ifid_valid ? fifo_pc_q[rd_ptr_q] : 64'h0;
  assign o_ifid_instruction = o_ifid_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;

  occupancy_bound_a : assert property (@(posedge i_clk) disable iff (i_rst)
    ((CW + 1)'(count_q) + (CW + 1)'(in_flight_q) <= DepthW));

endmodule
